// File: rtl/lc3b_types.sv
// Shared LC-3b types for the fetch slice: machine word, the per-instruction
// record carried from fetch to decode, and the fetch controller states.
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  typedef struct packed {
    lc3b_word inst;
    lc3b_word pc;
    logic     pred_taken;
    lc3b_word pred_target;
  } fetch_entry_t;

  typedef enum logic {
    REQ     = 1'b0,
    DISCARD = 1'b1
  } fetch_state_t;

  // Sequential successor of a fetch PC; 16-bit wrap so FFFE goes to 0000.
  function automatic lc3b_word pc_plus2(input lc3b_word pc);
    return pc + 16'd2;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular FIFO of fetch_entry_t between fetch and decode. Full/empty come
// from an explicit occupancy count; clear empties the queue in one edge.
// The head output reads as all-zero whenever the queue is empty.
module fetch_queue
  import lc3b_types::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          enq,
  input  fetch_entry_t  enq_data,
  input  logic          deq,
  output logic [CW-1:0] count,
  output logic          valid,
  output fetch_entry_t  head
);

  localparam int PW = $clog2(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] head_ptr;
  logic [PW-1:0] tail_ptr;

  // Pointer and occupancy bookkeeping; clear and reset both drop every entry.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (enq) tail_ptr <= tail_ptr + 1'b1;
      if (deq) head_ptr <= head_ptr + 1'b1;
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are meaningless until counted, so no reset needed.
  always_ff @(posedge clk) begin
    if (enq && !clear && !rst) mem[tail_ptr] <= enq_data;
  end

  assign valid = (count != '0);
  assign head  = valid ? mem[head_ptr] : '0;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, looks it up in the BTB, runs
// the I-cache read handshake and buffers fetched words for decode.
// A flush that lands while a read is in flight parks the controller in
// DISCARD so the stale response is swallowed at its original address.
// Optional feature: define FETCH_BTB_EN to follow BTB predictions; without
// it the PC always advances by 2 and nothing is ever predicted taken.
module fetch_unit
  import lc3b_types::*;
#(
  parameter int       QUEUE_DEPTH = 4,
  parameter lc3b_word RESET_PC    = 16'h0000
) (
  input  logic     clk,
  input  logic     rst,
  output lc3b_word icache_address,
  output logic     icache_read,
  input  lc3b_word icache_rdata,
  input  logic     icache_resp,
  output lc3b_word btb_pc,
  input  logic     btb_hit,
  input  lc3b_word btb_bta,
  input  logic     flush,
  input  lc3b_word flush_pc,
  input  logic     inst_deq,
  output logic     inst_valid,
  output lc3b_word inst,
  output lc3b_word inst_pc,
  output logic     inst_pred_taken,
  output lc3b_word inst_pred_target
);

  localparam int            CW         = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(QUEUE_DEPTH);

  fetch_state_t  state;
  lc3b_word      pc;
  lc3b_word      held_addr;
  lc3b_word      next_pc;
  logic          pred_hit;
  logic [CW-1:0] count;
  logic          enq;
  logic          deq;
  fetch_entry_t  enq_entry;
  fetch_entry_t  head;

`ifdef FETCH_BTB_EN
  assign pred_hit = btb_hit;
  assign next_pc  = btb_hit ? btb_bta : pc_plus2(pc);
`else
  logic unused_btb;
  assign unused_btb = btb_hit ^ (^btb_bta);
  assign pred_hit   = 1'b0;
  assign next_pc    = pc_plus2(pc);
`endif

  assign btb_pc         = pc;
  assign icache_read    = (state == DISCARD) || (count < FULL_COUNT);
  assign icache_address = (state == DISCARD) ? held_addr : pc;

  assign enq = (state == REQ) && icache_read && icache_resp && !flush;
  assign deq = inst_deq && inst_valid && !flush;

  assign enq_entry.inst        = icache_rdata;
  assign enq_entry.pc          = pc;
  assign enq_entry.pred_taken  = pred_hit;
  assign enq_entry.pred_target = next_pc;

  // Fetch controller: advance the PC on each response, redirect on flush and
  // remember the in-flight address when a flush orphans an outstanding read.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= REQ;
      pc        <= RESET_PC;
      held_addr <= RESET_PC;
    end else begin
      case (state)
        REQ: begin
          if (flush) begin
            pc <= flush_pc;
            if (icache_read && !icache_resp) begin
              state     <= DISCARD;
              held_addr <= pc;
            end
          end else if (icache_read && icache_resp) begin
            pc <= next_pc;
          end
        end
        DISCARD: begin
          if (flush) pc <= flush_pc;
          if (icache_resp) state <= REQ;
        end
        default: state <= REQ;
      endcase
    end
  end

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH),
    .CW    (CW)
  ) u_queue (
    .clk      (clk),
    .rst      (rst),
    .clear    (flush),
    .enq      (enq),
    .enq_data (enq_entry),
    .deq      (deq),
    .count    (count),
    .valid    (inst_valid),
    .head     (head)
  );

  assign inst             = head.inst;
  assign inst_pc          = head.pc;
  assign inst_pred_taken  = head.pred_taken;
  assign inst_pred_target = head.pred_target;

endmodule
